// File: rtl/comp_seq_nbit_if.sv
// Start/busy/done handshake and operand bus for the sequential magnitude comparator.
// The requester drives operands and start; the comparator returns status and the s/e/g result.
interface comp_seq_nbit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             s;
    logic             e;
    logic             g;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, s, e, g
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, s, e, g
    );
endinterface

// File: rtl/comp_seq_nbit.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, with early exit.
// Optional two's-complement mode. Result is reported through a start/busy/done handshake.
module comp_seq_nbit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    comp_seq_nbit_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    logic             busy_q;
    logic             done_q;
    logic             s_q;
    logic             e_q;
    logic             g_q;

    // Flipping the sign bit of both operands turns two's-complement order into unsigned
    // order, so the signed mode is folded into the operand registers at load time.
    logic [WIDTH-1:0] flip;
    assign flip = bus.signed_mode ? MSB_MASK : '0;

    // Operands shift left after each equal digit, so the current digit is always on top.
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    assign a_dig = a_q[WIDTH-1 -: DIGIT];
    assign b_dig = b_q[WIDTH-1 -: DIGIT];

    // NOTE: all state below is sequential, so every assignment uses <= to avoid
    // read-after-write ordering races between registers updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= IDX_TOP;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            s_q    <= 1'b0;
            e_q    <= 1'b0;
            g_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a ^ flip;
                        b_q    <= bus.b ^ flip;
                        idx    <= IDX_TOP;
                        busy_q <= 1'b1;
                        state  <= CMP;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CMP: begin
                    if ((a_dig != b_dig) || (idx == '0)) begin
                        s_q    <= (a_dig <  b_dig);
                        e_q    <= (a_dig == b_dig);
                        g_q    <= (a_dig >  b_dig);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        a_q    <= a_q << DIGIT;
                        b_q    <= b_q << DIGIT;
                        idx    <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.e    = e_q;
    assign bus.g    = g_q;
endmodule
